// File: rtl/serial_dump_pkg.sv
// serial_dump_pkg: command codes, FSM encodings and dump mode shared by the serial dumper
package serial_dump_pkg;
    localparam logic [7:0] CMD_READ  = 8'h72;
    localparam logic [7:0] CMD_PACK  = 8'h70;
    localparam logic [7:0] CMD_ABORT = 8'h78;
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_POP  = 4'd1;
    localparam logic [3:0] ST_DEC  = 4'd2;
    localparam logic [3:0] ST_HDR  = 4'd3;
    localparam logic [3:0] ST_RD   = 4'd4;
    localparam logic [3:0] ST_MEMW = 4'd5;
    localparam logic [3:0] ST_SEND = 4'd6;
    localparam logic [3:0] ST_WTX  = 4'd7;
    localparam logic [3:0] ST_NXT  = 4'd8;
    localparam logic [3:0] ST_POPA = 4'd9;
    localparam logic [3:0] ST_ADEC = 4'd10;
    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_WBH  = 2'd1;
    localparam logic [1:0] TX_WBL  = 2'd2;
    typedef enum logic {MODE_UNPACKED, MODE_PACKED} mode_t;
endpackage

// File: rtl/serial_dump_if.sv
// serial_dump_if: RX FIFO, TX and pixel memory signals of the serial dumper
interface serial_dump_if #(parameter int PIX_W = 4, parameter int ADDR_W = 13);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_fifo_read;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic              pix_rd_en;
    logic [PIX_W-1:0]  pix_rd_data;
    modport master (
        input  rx_valid, rx_data, tx_busy, pix_rd_data,
        output rx_fifo_read, tx_start, tx_data, pix_rd_addr, pix_rd_en
    );
    modport slave (
        output rx_valid, rx_data, tx_busy, pix_rd_data,
        input  rx_fifo_read, tx_start, tx_data, pix_rd_addr, pix_rd_en
    );
endinterface

// File: rtl/tx_byte_sender.sv
// tx_byte_sender: start strobe plus busy-rise/busy-fall handshake with a rise timeout
module tx_byte_sender #(parameter int TX_WAIT = 15) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic tx_busy,
    output logic tx_start,
    output logic done
);
    import serial_dump_pkg::*;
    localparam int CW = $clog2(TX_WAIT + 2);
    logic [1:0]    phase;
    logic [CW-1:0] cnt;
    logic          timeout;
    assign timeout  = cnt == CW'(TX_WAIT);
    assign tx_start = req && phase == TX_IDLE;
    // busy rising on the timeout cycle wins: WBH only finishes on timeout when busy is still low
    assign done     = !tx_busy && ((phase == TX_WBH && timeout) || phase == TX_WBL);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            phase <= TX_IDLE;
            cnt   <= '0;
        end else if (tx_start) begin
            phase <= TX_WBH;
            cnt   <= '0;
        end else if (phase == TX_WBH) begin
            phase <= tx_busy ? TX_WBL : (timeout ? TX_IDLE : TX_WBH);
            cnt   <= cnt + 1'b1;
        end else if (done)
            phase <= TX_IDLE;
endmodule

// File: rtl/serial_dump_ctrl.sv
// serial_dump_ctrl: command-driven pixel memory dumper from the UART RX FIFO to the UART TX
module serial_dump_ctrl #(
    parameter int         PIX_W    = 4,
    parameter int         ADDR_W   = 13,
    parameter int         DEPTH    = 8192,
    parameter int         MEM_LAT  = 1,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter int         TX_WAIT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    serial_dump_if.master bus,
    output logic          busy,
    output logic          cmd_error,
    output logic [7:0]    last_cmd
);
    import serial_dump_pkg::*;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    logic [3:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        wcnt;
    mode_t             mode;
    logic              half, hdr, req, done, last;
    logic [7:0]        pix8;
    assign pix8             = 8'(bus.pix_rd_data);
    assign last             = addr == LAST;
    assign req              = state == ST_SEND;
    assign bus.rx_fifo_read = state == ST_POP || state == ST_POPA;
    assign bus.pix_rd_en    = state == ST_RD;
    assign bus.pix_rd_addr  = addr;
    assign busy             = !(state == ST_IDLE || state == ST_POP || state == ST_DEC);
    tx_byte_sender #(.TX_WAIT(TX_WAIT)) u_tx (
        .clk(clk),
        .reset(reset),
        .req(req),
        .tx_busy(bus.tx_busy),
        .tx_start(bus.tx_start),
        .done(done)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= ST_IDLE;
            addr        <= '0;
            wcnt        <= '0;
            mode        <= MODE_UNPACKED;
            half        <= 1'b0;
            hdr         <= 1'b0;
            cmd_error   <= 1'b0;
            last_cmd    <= '0;
            bus.tx_data <= '0;
        end else begin
            cmd_error <= 1'b0;
            case (state)
                ST_IDLE: if (bus.rx_valid) state <= ST_POP;
                ST_POP:  state <= ST_DEC;
                ST_DEC:
                    if (bus.rx_data == CMD_READ || (bus.rx_data == CMD_PACK && PIX_W <= 4)) begin
                        mode     <= bus.rx_data == CMD_PACK ? MODE_PACKED : MODE_UNPACKED;
                        last_cmd <= bus.rx_data;
                        addr     <= '0;
                        half     <= 1'b0;
                        state    <= ST_HDR;
                    end else begin
                        cmd_error <= bus.rx_data != CMD_ABORT;
                        state     <= ST_IDLE;
                    end
                ST_HDR: begin
                    bus.tx_data <= HDR_BYTE;
                    hdr         <= 1'b1;
                    state       <= ST_SEND;
                end
                ST_RD: begin
                    wcnt  <= '0;
                    state <= ST_MEMW;
                end
                ST_MEMW:
                    if (wcnt != 2'(MEM_LAT - 1))
                        wcnt <= wcnt + 1'b1;
                    else if (mode == MODE_PACKED && !half) begin
                        bus.tx_data <= {4'h0, pix8[3:0]};
                        if (last)
                            state <= ST_SEND;
                        else begin
                            half  <= 1'b1;
                            addr  <= addr + 1'b1;
                            state <= ST_RD;
                        end
                    end else begin
                        bus.tx_data <= half ? {pix8[3:0], bus.tx_data[3:0]} : pix8;
                        half        <= 1'b0;
                        state       <= ST_SEND;
                    end
                ST_SEND: state <= ST_WTX;
                ST_WTX:
                    if (done) begin
                        hdr   <= 1'b0;
                        state <= hdr ? ST_RD : ST_NXT;
                    end
                ST_NXT:
                    if (last) begin
                        addr  <= '0;
                        state <= ST_IDLE;
                    end else if (bus.rx_valid)
                        state <= ST_POPA;
                    else begin
                        addr  <= addr + 1'b1;
                        state <= ST_RD;
                    end
                ST_POPA: state <= ST_ADEC;
                // a mid-dump byte other than abort is flagged and dropped; the dump resumes
                ST_ADEC:
                    if (bus.rx_data == CMD_ABORT) begin
                        addr  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cmd_error <= 1'b1;
                        addr      <= addr + 1'b1;
                        state     <= ST_RD;
                    end
                default: state <= ST_IDLE;
            endcase
        end
endmodule

// File: tb/tb_serial_dump_ctrl.sv
// tb_serial_dump_ctrl: scoreboard bench with RX FIFO, TX and pixel memory models
module tb_serial_dump_ctrl;
    localparam int PIX_W   = 4;
    localparam int ADDR_W  = 13;
    localparam int DEPTH   = 7;
    localparam int MEM_LAT = 3;
    localparam int TX_WAIT = 15;
    localparam int GAP     = 1 + (TX_WAIT + 1) + 1 + 1 + MEM_LAT;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, cmd_error;
    logic [7:0] last_cmd;
    serial_dump_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus();
    serial_dump_ctrl #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT),
        .HDR_BYTE(8'hA5), .TX_WAIT(TX_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .busy(busy), .cmd_error(cmd_error), .last_cmd(last_cmd)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    int starts = 0, rx_reads = 0, err_cycles = 0, cyc = 0, last_start = 0, bcnt = 0;
    int s0, r0, e0;
    logic mute = 1'b0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int gaps[$];
    logic [PIX_W-1:0] pipe[MEM_LAT];
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    // pixel memory holds mem[i] = i, read through a MEM_LAT-deep pipeline
    always @(posedge clk) begin
        if (bus.pix_rd_en) pipe[0] <= PIX_W'(bus.pix_rd_addr);
        for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pix_rd_data = pipe[MEM_LAT-1];
    always @(posedge clk)
        if (bus.rx_fifo_read && rxq.size() != 0) bus.rx_data <= rxq.pop_front();
    always @(negedge clk) begin
        cyc++;
        bus.rx_valid = rxq.size() != 0;
        rx_reads += int'(bus.rx_fifo_read);
        err_cycles += int'(cmd_error);
        if (!reset) begin
            bus.tx_busy = 1'b0;
            bcnt = 0;
        end else if (bus.tx_start) begin
            starts++;
            gaps.push_back(cyc - last_start);
            last_start = cyc;
            check("tx_start_while_busy", bus.tx_busy, 0);
            if (expq.size() == 0) check("tx_unexpected_byte", bus.tx_data, 64'hFFFF);
            else check("tx_byte", bus.tx_data, expq.pop_front());
            if (!mute) begin
                bus.tx_busy = 1'b1;
                bcnt = 3;
            end
        end else if (bus.tx_busy) begin
            if (bcnt == 0) bus.tx_busy = 1'b0;
            else bcnt--;
        end
    end
    task automatic push_r();
        expq.push_back(8'hA5);
        for (int i = 0; i < DEPTH; i++) expq.push_back(8'(i));
    endtask
    task automatic push_p();
        expq.push_back(8'hA5);
        for (int i = 0; i < DEPTH; i += 2) expq.push_back({((i + 1) < DEPTH) ? 4'(i + 1) : 4'h0, 4'(i)});
    endtask
    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) check({tag, "_busy_timeout"}, busy, lvl);
    endtask
    task automatic wait_starts(input int target, input string tag);
        int n = 0;
        while (starts - s0 < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (starts - s0 < target) check({tag, "_start_timeout"}, starts - s0, target);
    endtask
    task automatic finish_dump(input string tag, input int nbytes);
        wait_busy(1'b0, tag);
        check({tag, "_bytes_at_idle"}, starts - s0, nbytes);
        repeat (12) @(negedge clk);
        check({tag, "_bytes_total"}, starts - s0, nbytes);
        check({tag, "_scoreboard_drained"}, expq.size(), 0);
    endtask
    task automatic run_dump(input logic [7:0] c, input string tag, input int nbytes);
        s0 = starts;
        rxq.push_back(c);
        wait_busy(1'b1, tag);
        finish_dump(tag, nbytes);
    endtask
    task automatic run_inject(input logic [7:0] inj, input string tag, input int nbytes, input int nerr);
        s0 = starts;
        r0 = rx_reads;
        e0 = err_cycles;
        rxq.push_back(8'h72);
        wait_starts(4, tag);
        rxq.push_back(inj);
        finish_dump(tag, nbytes);
        check({tag, "_rx_reads"}, rx_reads - r0, 2);
        check({tag, "_err_cycles"}, err_cycles - e0, nerr);
    endtask
    task automatic run_idle_cmd(input logic [7:0] c, input string tag, input int nerr);
        s0 = starts;
        r0 = rx_reads;
        e0 = err_cycles;
        rxq.push_back(c);
        repeat (10) @(negedge clk);
        check({tag, "_err_cycles"}, err_cycles - e0, nerr);
        check({tag, "_rx_reads"}, rx_reads - r0, 1);
        check({tag, "_no_tx"}, starts - s0, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_last_cmd"}, last_cmd, 8'h70);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        #2;
        check("reset_outputs", {bus.tx_start, bus.rx_fifo_read, bus.pix_rd_en, busy, cmd_error, last_cmd, bus.tx_data, bus.pix_rd_addr}, 0);
        reset = 1'b1;
        @(negedge clk);
        push_r();
        run_dump(8'h72, "read", DEPTH + 1);
        check("read_last_cmd", last_cmd, 8'h72);
        push_p();
        run_dump(8'h70, "pack", (DEPTH + 1) / 2 + 1);
        check("pack_last_cmd", last_cmd, 8'h70);
        run_idle_cmd(8'h71, "bad_cmd", 1);
        run_idle_cmd(8'h78, "idle_abort", 0);
        expq.push_back(8'hA5);
        for (int i = 0; i < 3; i++) expq.push_back(8'(i));
        run_inject(8'h78, "abort", 4, 0);
        push_r();
        run_inject(8'h7A, "junk", DEPTH + 1, 1);
        mute = 1'b1;
        push_r();
        gaps.delete();
        run_dump(8'h72, "mute", DEPTH + 1);
        check("mute_gap_d1_d2", gaps.size() > 3 ? gaps[3] : 0, GAP);
        check("mute_gap_last", gaps.size() > DEPTH ? gaps[DEPTH] : 0, GAP);
        mute = 1'b0;
        push_r();
        s0 = starts;
        rxq.push_back(8'h72);
        wait_starts(3, "reset_mid");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset_async_outputs", {bus.tx_start, bus.rx_fifo_read, bus.pix_rd_en, busy, cmd_error, last_cmd, bus.tx_data, bus.pix_rd_addr}, 0);
        expq.delete();
        rxq.delete();
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        s0 = starts;
        repeat (20) @(negedge clk);
        check("reset_no_tx", starts - s0, 0);
        check("reset_idle", busy, 0);
        push_r();
        run_dump(8'h72, "post_reset", DEPTH + 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
